// File: rtl/axil_rr_mstr_recorder.sv
// Inline AXI-Lite record stage: logs every master-side AW/W/AR handshake into a
// FWFT FIFO drained over a valid/ready stream, back-pressuring the link when full.
module axil_rr_mstr_recorder #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             record_en,
    input  logic [31:0]      m_awaddr,
    input  logic             m_awvalid,
    output logic             m_awready,
    input  logic [31:0]      m_wdata,
    input  logic [3:0]       m_wstrb,
    input  logic             m_wvalid,
    output logic             m_wready,
    input  logic [31:0]      m_araddr,
    input  logic             m_arvalid,
    output logic             m_arready,
    output logic [1:0]       m_bresp,
    output logic             m_bvalid,
    input  logic             m_bready,
    output logic [31:0]      m_rdata,
    output logic [1:0]       m_rresp,
    output logic             m_rvalid,
    input  logic             m_rready,
    output logic [31:0]      s_awaddr,
    output logic             s_awvalid,
    input  logic             s_awready,
    output logic [31:0]      s_wdata,
    output logic [3:0]       s_wstrb,
    output logic             s_wvalid,
    input  logic             s_wready,
    output logic [31:0]      s_araddr,
    output logic             s_arvalid,
    input  logic             s_arready,
    input  logic [1:0]       s_bresp,
    input  logic             s_bvalid,
    output logic             s_bready,
    input  logic [31:0]      s_rdata,
    input  logic [1:0]       s_rresp,
    input  logic             s_rvalid,
    output logic             s_rready,
    output logic [102:0]     log_data,
    output logic             log_valid,
    input  logic             log_ready,
    output logic [CNT_W-1:0] log_count,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int             AW     = $clog2(DEPTH);
    localparam logic [AW:0]    C_FULL = (AW+1)'(DEPTH);

    logic                r_en_q;
    logic [102:0]        r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [AW:0]         r_count;
    logic [CNT_W-1:0]    r_log_count;
    logic [CNT_W-1:0]    r_stall_cycles;

    logic                w_stall;
    logic                w_hs_aw;
    logic                w_hs_w;
    logic                w_hs_ar;
    logic                w_push;
    logic                w_pop;
    logic [102:0]        w_entry;

    // rst forces stall low so an in-flight valid passes ungated in the reset cycle
    assign w_stall   = ~rst & r_en_q & (r_count == C_FULL);

    assign s_awaddr  = m_awaddr;
    assign s_awvalid = m_awvalid & ~w_stall;
    assign m_awready = s_awready & ~w_stall;
    assign s_wdata   = m_wdata;
    assign s_wstrb   = m_wstrb;
    assign s_wvalid  = m_wvalid & ~w_stall;
    assign m_wready  = s_wready & ~w_stall;
    assign s_araddr  = m_araddr;
    assign s_arvalid = m_arvalid & ~w_stall;
    assign m_arready = s_arready & ~w_stall;

    assign m_bresp   = s_bresp;
    assign m_bvalid  = s_bvalid;
    assign s_bready  = m_bready;
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_rvalid  = s_rvalid;
    assign s_rready  = m_rready;

    assign w_hs_aw   = m_awvalid & m_awready;
    assign w_hs_w    = m_wvalid & m_wready;
    assign w_hs_ar   = m_arvalid & m_arready;
    assign w_push    = r_en_q & (w_hs_aw | w_hs_w | w_hs_ar);
    assign w_pop     = log_valid & log_ready;

    assign w_entry = {w_hs_aw, w_hs_w, w_hs_ar,
                      w_hs_aw ? m_awaddr : 32'h0,
                      w_hs_w  ? m_wdata  : 32'h0,
                      w_hs_w  ? m_wstrb  : 4'h0,
                      w_hs_ar ? m_araddr : 32'h0};

    assign log_valid    = (r_count != '0);
    assign log_data     = r_mem[r_rptr];
    assign log_count    = r_log_count;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_q         <= 1'b0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_log_count    <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_en_q <= record_en;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && (r_log_count != '1)) begin
                r_log_count <= r_log_count + CNT_W'(1);
            end
            if (w_stall && (m_awvalid || m_wvalid || m_arvalid) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axil_rr_mstr_recorder.sv
// Directed self-checking bench for axil_rr_mstr_recorder (DEPTH=16).
module tb_axil_rr_mstr_recorder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         record_en = 1'b1;
    logic [31:0]  m_awaddr = '0;
    logic         m_awvalid = 1'b0;
    logic         m_awready;
    logic [31:0]  m_wdata = '0;
    logic [3:0]   m_wstrb = '0;
    logic         m_wvalid = 1'b0;
    logic         m_wready;
    logic [31:0]  m_araddr = '0;
    logic         m_arvalid = 1'b0;
    logic         m_arready;
    logic [1:0]   m_bresp;
    logic         m_bvalid;
    logic         m_bready = 1'b0;
    logic [31:0]  m_rdata;
    logic [1:0]   m_rresp;
    logic         m_rvalid;
    logic         m_rready = 1'b0;
    logic [31:0]  s_awaddr;
    logic         s_awvalid;
    logic         s_awready = 1'b1;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic         s_wvalid;
    logic         s_wready = 1'b1;
    logic [31:0]  s_araddr;
    logic         s_arvalid;
    logic         s_arready = 1'b1;
    logic [1:0]   s_bresp = '0;
    logic         s_bvalid = 1'b0;
    logic         s_bready;
    logic [31:0]  s_rdata = '0;
    logic [1:0]   s_rresp = '0;
    logic         s_rvalid = 1'b0;
    logic         s_rready;
    logic [102:0] log_data;
    logic         log_valid;
    logic         log_ready = 1'b0;
    logic [31:0]  log_count;
    logic [31:0]  stall_cycles;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned exp_lc = 0;
    logic [31:0] q[$];

    axil_rr_mstr_recorder #(.DEPTH(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .record_en(record_en),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .log_data(log_data), .log_valid(log_valid), .log_ready(log_ready),
        .log_count(log_count), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [102:0] obs, input logic [102:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_log_valid", 103'(log_valid), 103'(0));
        chk("rst_log_count", 103'(log_count), 103'(0));
        chk("rst_stall_cycles", 103'(stall_cycles), 103'(0));
        chk("rst_arready", 103'(m_arready), 103'(1));
        step();

        // single write
        m_awvalid = 1'b1; m_awaddr = 32'h10;
        m_wvalid = 1'b1; m_wdata = 32'hDEADBEEF; m_wstrb = 4'hF;
        chk("w1_s_awvalid", 103'(s_awvalid), 103'(1));
        chk("w1_pre_valid", 103'(log_valid), 103'(0));
        step();
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        exp_lc = 1;
        chk("w1_valid", 103'(log_valid), 103'(1));
        chk("w1_data", log_data, {3'b110, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0});
        chk("w1_count", 103'(log_count), 103'(exp_lc));
        log_ready = 1'b1;
        step();
        log_ready = 1'b0;
        chk("w1_drained", 103'(log_valid), 103'(0));

        // split write plus read
        m_awvalid = 1'b1; m_awaddr = 32'h30;
        step();
        m_awvalid = 1'b0;
        step();
        m_wvalid = 1'b1; m_wdata = 32'h12345678; m_wstrb = 4'h3;
        m_arvalid = 1'b1; m_araddr = 32'h20;
        step();
        m_wvalid = 1'b0; m_arvalid = 1'b0;
        exp_lc = 3;
        chk("sp_count", 103'(log_count), 103'(exp_lc));
        chk("sp_e0", log_data, {3'b100, 32'h30, 32'h0, 4'h0, 32'h0});
        log_ready = 1'b1;
        step();
        chk("sp_e1", log_data, {3'b011, 32'h0, 32'h12345678, 4'h3, 32'h20});
        step();
        log_ready = 1'b0;
        chk("sp_empty", 103'(log_valid), 103'(0));

        // back-pressure with 17 reads
        m_arvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_araddr = 32'h100 + 32'(i);
            step();
        end
        m_araddr = 32'h110;
        exp_lc += 16;
        chk("bp_arready", 103'(m_arready), 103'(0));
        chk("bp_s_arvalid", 103'(s_arvalid), 103'(0));
        chk("bp_count", 103'(log_count), 103'(exp_lc));
        step(); step(); step();
        chk("bp_stall3", 103'(stall_cycles), 103'(3));
        chk("bp_head", log_data, {3'b001, 32'h0, 32'h0, 4'h0, 32'h100});
        log_ready = 1'b1;
        step();
        log_ready = 1'b0;
        chk("bp_stall4", 103'(stall_cycles), 103'(4));
        chk("bp_release", 103'(m_arready), 103'(1));
        step();
        exp_lc += 1;
        chk("bp_refull", 103'(m_arready), 103'(0));
        chk("bp_count17", 103'(log_count), 103'(exp_lc));

        // concurrent push/pop at full
        for (int i = 1; i <= 16; i++) q.push_back(32'h100 + 32'(i));
        log_ready = 1'b1;
        m_araddr = 32'h200;
        for (int c = 0; c < 20; c++) begin
            logic exp_full;
            exp_full = (q.size() == 16);
            chk("cc_arready", 103'(m_arready), 103'(!exp_full));
            chk("cc_head", log_data, {3'b001, 32'h0, 32'h0, 4'h0, q[0]});
            step();
            void'(q.pop_front());
            if (!exp_full) begin
                q.push_back(m_araddr);
                m_araddr = m_araddr + 32'h1;
                exp_lc++;
            end
        end
        m_arvalid = 1'b0;
        while (q.size() > 0) begin
            chk("dr_valid", 103'(log_valid), 103'(1));
            chk("dr_head", log_data, {3'b001, 32'h0, 32'h0, 4'h0, q[0]});
            step();
            void'(q.pop_front());
        end
        log_ready = 1'b0;
        chk("dr_empty", 103'(log_valid), 103'(0));
        chk("dr_count", 103'(log_count), 103'(exp_lc));
        chk("dr_stall", 103'(stall_cycles), 103'(5));

        // recording disabled
        record_en = 1'b0;
        step();
        m_awvalid = 1'b1; m_wvalid = 1'b1;
        s_bvalid = 1'b1; s_bresp = 2'b10; s_rvalid = 1'b1; s_rresp = 2'b01;
        for (int i = 0; i < 5; i++) begin
            m_awaddr = 32'h400 + 32'(i);
            s_rdata = 32'hA5A50000 + 32'(i);
            m_bready = i[0];
            #1;
            chk("dis_awready", 103'(m_awready), 103'(1));
            chk("dis_s_wvalid", 103'(s_wvalid), 103'(1));
            chk("dis_s_awaddr", 103'(s_awaddr), 103'(32'h400 + 32'(i)));
            chk("dis_b", 103'({m_bvalid, m_bresp, s_bready}), 103'({1'b1, 2'b10, i[0]}));
            chk("dis_r", 103'({m_rvalid, m_rresp, m_rdata}), 103'({1'b1, 2'b01, 32'hA5A50000 + 32'(i)}));
            step();
        end
        s_awready = 1'b0;
        #1;
        chk("dis_gate_ready", 103'(m_awready), 103'(0));
        s_awready = 1'b1;
        m_awvalid = 1'b0; m_wvalid = 1'b0; s_bvalid = 1'b0; s_rvalid = 1'b0;
        chk("dis_no_entry", 103'(log_valid), 103'(0));
        chk("dis_count", 103'(log_count), 103'(exp_lc));

        // reset mid-operation
        record_en = 1'b1;
        step();
        m_awvalid = 1'b1; m_wvalid = 1'b1;
        step(); step(); step(); step();
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        chk("rm_count4", 103'(log_count), 103'(exp_lc + 4));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rm_valid", 103'(log_valid), 103'(0));
        chk("rm_count", 103'(log_count), 103'(0));
        chk("rm_stall", 103'(stall_cycles), 103'(0));
        step();
        m_awvalid = 1'b1; m_awaddr = 32'h44;
        m_wvalid = 1'b1; m_wdata = 32'h55; m_wstrb = 4'h1;
        step();
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        chk("rm_first", log_data, {3'b110, 32'h44, 32'h55, 4'h1, 32'h0});
        chk("rm_count1", 103'(log_count), 103'(1));

        // fill, then disable while full, then reset while full
        m_arvalid = 1'b1; m_araddr = 32'h300;
        for (int i = 0; i < 15; i++) step();
        chk("fl_stalled", 103'(m_arready), 103'(0));
        record_en = 1'b0;
        #1;
        chk("fl_en_delay", 103'(m_arready), 103'(0));
        step();
        chk("fl_released", 103'(m_arready), 103'(1));
        chk("fl_kept", 103'(log_valid), 103'(1));
        record_en = 1'b1;
        step();
        chk("fl_restall", 103'(m_arready), 103'(0));
        chk("fl_count", 103'(log_count), 103'(16));
        rst = 1'b1;
        #1;
        chk("fl_rst_ready", 103'(m_arready), 103'(1));
        chk("fl_rst_svalid", 103'(s_arvalid), 103'(1));
        step();
        rst = 1'b0;
        m_arvalid = 1'b0;
        chk("fl_rst_empty", 103'(log_valid), 103'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
